spmv_mem_arbiter: RTL and testbench
===================================

Name: spmv_mem_arbiter

Overview:
- Shares the single PE main-memory port (48-bit address, 64-bit data-or-tag, 3-bit response tag) among the PE's stream fetchers: spm code, spm arg, fzip code, fzip arg, x-vector and y-store.
- Arbitration is round-robin, with a registered request stage toward memory.
- The requester index is carried as the load tag, and responses are routed back by tag.
- Per-requester outstanding-load credits prevent response-FIFO overflow. A busy output feeds the PE busy_out.

Parameters:
- NUM_REQ, 6, number of requesters; legal range 1..8 (limited by the 3-bit tag)
- ADDR_W, 48, memory address width
- DATA_W, 64, data / data-or-tag width
- TAG_W, 3, response tag width
- MAX_OUT, 16, maximum outstanding loads per requester
- CNT_W, 5, credit counter width; must satisfy 2^CNT_W > MAX_OUT

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- req_ld  in  NUM_REQ  per-requester load request
- req_st  in  NUM_REQ  per-requester store request
- req_addr  in  NUM_REQ*ADDR_W  packed request addresses; requester i occupies slice i
- req_d  in  NUM_REQ*DATA_W  packed store data
- req_stall  out  NUM_REQ  1 = request not accepted this cycle
- rsp_push  out  NUM_REQ  one-hot load-response strobe
- rsp_q  out  DATA_W  response data, shared by all requesters
- rsp_stall  in  NUM_REQ  requester response FIFO almost full
- mem_req_ld  out  1  load to memory
- mem_req_st  out  1  store to memory
- mem_req_addr  out  ADDR_W  memory address
- mem_req_d_or_tag  out  DATA_W  store data, or load tag zero-extended
- mem_req_stall  in  1  memory cannot accept a request
- mem_rsp_push  in  1  load response valid
- mem_rsp_tag  in  TAG_W  load response tag
- mem_rsp_q  in  DATA_W  load response data
- mem_rsp_stall  out  1  response backpressure to memory
- busy  out  1  outstanding loads or a pending request exist
- tag_err  out  1  sticky: response received with tag >= NUM_REQ

Behaviour:
- Request handshake
  - A requester asserts ld or st (never both) and holds addr/d until a cycle in which req_stall[i]=0; the transfer happens that cycle.
  - req_stall[i] = ~grant[i], combinational.
- Eligibility for requester i:
  - (req_ld[i] & cnt[i] < MAX_OUT) | req_st[i]
  - mem_req_stall=0 is additionally required; otherwise no grant is issued that cycle.
- Round-robin arbitration
  - The search starts at pointer rr and takes the first eligible requester; at most one grant per cycle.
  - After a grant to i, rr <= (i+1) mod NUM_REQ. With no grant, rr is unchanged.
- Issue latency
  - The grant is registered; mem_req_ld/st is asserted exactly one cycle after the accept cycle, and held for one cycle only.
  - mem_req_d_or_tag = store data for a store, or {0, i} for a load.
- Credits
  - cnt[i] increments on a load grant to i and decrements on mem_rsp_push with tag i.
  - If both happen in the same cycle, cnt[i] is unchanged.
  - A decrement when cnt[i]=0 saturates at 0 (covers stray post-reset responses).
- Response path
  - rsp_push[tag] <= mem_rsp_push, and rsp_q <= mem_rsp_q; one cycle latency, registered.
  - A tag >= NUM_REQ pushes nothing and sets tag_err.
- mem_rsp_stall = |(rsp_stall & ~{NUM_REQ{1'b0}}) is simply the OR of rsp_stall, registered. Requesters must size their FIFOs for MAX_OUT entries plus a skid of 4.
- busy = (any cnt != 0) | mem_req_ld | mem_req_st | (any req_ld | req_st).
- Reset (rst_n=0 at posedge)
  - Forces to 0: all mem_req_*, rsp_push, rsp_q, mem_rsp_stall, tag_err, rr and every cnt.
  - req_stall is all ones while rst_n=0.
  - Reset applied mid-operation discards any registered request; requesters re-present after reset.
- State machine: none beyond the rr pointer, the credit counters and the one-deep issue register. An implicit state of IDLE/ISSUE is carried by the mem_req valid bit.

Decomposition:
- Shared package or include (alongside the opcode include) holds: SPMV_MEM_ADDR_W=48, SPMV_MEM_DATA_W=64, SPMV_MEM_TAG_W=3, and requester index constants: REQ_SPM_CODE=0, REQ_SPM_ARG=1, REQ_FZIP_CODE=2, REQ_FZIP_ARG=3, REQ_X=4, REQ_Y_ST=5.
- One sub-module, spmv_rr_arbiter: parameterised NUM_REQ round-robin picker. Inputs: eligible vector and rr pointer. Outputs: one-hot grant and next pointer.

Test Plan:
- Single requester: req_ld[2]=1, addr=0x100 → accepted in cycle 0; mem_req_ld=1, addr=0x100, d_or_tag=2 in cycle 1; response tag 2 with q=0xDEAD → rsp_push=6'b000100, rsp_q=0xDEAD one cycle later; busy drops to 0.
- All 6 requesters asserting loads continuously → grants rotate in the order 0,1,2,3,4,5,0; no requester is starved; exactly one mem_req_ld per cycle.
- mem_req_stall=1 for 5 cycles with 3 pending requesters → no mem_req_ld during the stall, all req_stall=1; after release, issue resumes from the unchanged rr.
- Requester 0 issues 16 loads with no responses → 17th load stalled while requester 1 continues to be served. One response with tag 0 → requester 0 is eligible again. A grant and a response in the same cycle leave cnt unchanged.
- Store from requester 5: addr=0x2000, d=0x3FF0000000000000 → mem_req_st=1 with d_or_tag=0x3FF0000000000000; cnt[5] remains 0; no rsp_push.
- Response with tag 7 → no rsp_push and tag_err=1. Reset with 4 loads outstanding → all counters 0, busy=0; a late tag-1 response pushes rsp_push[1] and cnt[1] stays 0.

Source files
------------

// File: rtl/spmv_mem_arbiter_pkg.sv
// Shared constants for the PE main-memory arbiter.
// Requester indices double as the memory load tag.
package spmv_mem_arbiter_pkg;

  localparam int SPMV_MEM_ADDR_W = 48;
  localparam int SPMV_MEM_DATA_W = 64;
  localparam int SPMV_MEM_TAG_W  = 3;

  localparam int REQ_SPM_CODE  = 0;
  localparam int REQ_SPM_ARG   = 1;
  localparam int REQ_FZIP_CODE = 2;
  localparam int REQ_FZIP_ARG  = 3;
  localparam int REQ_X         = 4;
  localparam int REQ_Y_ST      = 5;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spmv_mem_arbiter_if.sv
// PE main-memory port: request, response and backpressure.
// master = arbiter side, slave = memory side.
interface spmv_mem_arbiter_if
  import spmv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = SPMV_MEM_ADDR_W,
  parameter int DATA_W = SPMV_MEM_DATA_W,
  parameter int TAG_W  = SPMV_MEM_TAG_W
);
  logic              mem_req_ld;
  logic              mem_req_st;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_d_or_tag;
  logic              mem_req_stall;
  logic              mem_rsp_push;
  logic [TAG_W-1:0]  mem_rsp_tag;
  logic [DATA_W-1:0] mem_rsp_q;
  logic              mem_rsp_stall;

  modport master (
    output mem_req_ld, mem_req_st,
    output mem_req_addr, mem_req_d_or_tag,
    input  mem_req_stall,
    input  mem_rsp_push, mem_rsp_tag,
    input  mem_rsp_q,
    output mem_rsp_stall
  );

  modport slave (
    input  mem_req_ld, mem_req_st,
    input  mem_req_addr, mem_req_d_or_tag,
    output mem_req_stall,
    output mem_rsp_push, mem_rsp_tag,
    output mem_rsp_q,
    input  mem_rsp_stall
  );
endinterface

// File: rtl/spmv_rr_arbiter.sv
// Round-robin picker: first eligible requester at or after rr.
// Pointer advances past the winner; unchanged when nobody wins.
module spmv_rr_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   rr_next
);
  localparam logic [PTR_W:0] N_C = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] sum;
  logic           found;

  always_comb begin
    grant   = '0;
    rr_next = rr;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr} + (PTR_W+1)'(k);
      if (sum >= N_C) sum = sum - N_C;
      if (!found && eligible[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        grant[sum[PTR_W-1:0]] = 1'b1;
        rr_next = (sum + 1'b1 == N_C) ? '0
                : PTR_W'(sum + 1'b1);
      end
    end
  end
endmodule

// File: rtl/spmv_mem_arbiter.sv
// Shares the PE memory port among stream fetchers with RR
// arbitration, tag-routed responses and per-requester credits.
module spmv_mem_arbiter
  import spmv_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int ADDR_W  = SPMV_MEM_ADDR_W,
  parameter int DATA_W  = SPMV_MEM_DATA_W,
  parameter int TAG_W   = SPMV_MEM_TAG_W,
  parameter int MAX_OUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_ld,
  input  logic [NUM_REQ-1:0]        req_st,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_d,
  output logic [NUM_REQ-1:0]        req_stall,
  output logic [NUM_REQ-1:0]        rsp_push,
  output logic [DATA_W-1:0]         rsp_q,
  input  logic [NUM_REQ-1:0]        rsp_stall,
  spmv_mem_arbiter_if.master        mem,
  output logic                      busy,
  output logic                      tag_err
);
  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [PTR_W-1:0]   rr, rr_next;
  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig, grant;
  logic [NUM_REQ-1:0] gnt_ld, gnt_st;
  logic [NUM_REQ-1:0] rsp_hit, cnt_nz;
  logic [ADDR_W-1:0]  gaddr;
  logic [DATA_W-1:0]  gdata;
  logic               tag_bad;

  always_comb begin
    elig    = '0;
    rsp_hit = '0;
    cnt_nz  = '0;
    gaddr   = '0;
    gdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_n & ~mem.mem_req_stall
              & ((req_ld[i] & (cnt[i] < MAX_C))
                 | req_st[i]);
      rsp_hit[i] = mem.mem_rsp_push
                 & (mem.mem_rsp_tag == TAG_W'(i));
      cnt_nz[i] = |cnt[i];
      if (grant[i]) begin
        gaddr = req_addr[i*ADDR_W +: ADDR_W];
        gdata = req_st[i] ? req_d[i*DATA_W +: DATA_W]
                          : DATA_W'(i);
      end
    end
  end

  spmv_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .eligible (elig),
    .rr       (rr),
    .grant    (grant),
    .rr_next  (rr_next)
  );

  assign gnt_ld    = grant & req_ld;
  assign gnt_st    = grant & req_st;
  assign req_stall = ~grant;
  assign tag_bad   = mem.mem_rsp_push
                   & (32'(mem.mem_rsp_tag) >= NUM_REQ);

  assign busy = (|cnt_nz) | mem.mem_req_ld | mem.mem_req_st
              | (|(req_ld | req_st));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem.mem_req_ld       <= 1'b0;
      mem.mem_req_st       <= 1'b0;
      mem.mem_req_addr     <= '0;
      mem.mem_req_d_or_tag <= '0;
      mem.mem_rsp_stall    <= 1'b0;
      rsp_push             <= '0;
      rsp_q                <= '0;
      tag_err              <= 1'b0;
      rr                   <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      mem.mem_req_ld <= |gnt_ld;
      mem.mem_req_st <= |gnt_st;
      if (|grant) begin
        mem.mem_req_addr     <= gaddr;
        mem.mem_req_d_or_tag <= gdata;
      end
      mem.mem_rsp_stall <= |rsp_stall;
      rsp_push          <= rsp_hit;
      rsp_q             <= mem.mem_rsp_q;
      tag_err           <= tag_err | tag_bad;
      rr                <= rr_next;
      // simultaneous grant and response cancel out
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_ld[i] && !rsp_hit[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (rsp_hit[i] && !gnt_ld[i] && cnt_nz[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_spmv_mem_arbiter;
  import spmv_mem_arbiter_pkg::*;

  localparam int N  = 6;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int MO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_ld, req_st, req_stall;
  logic [N-1:0]    rsp_push, rsp_stall;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_d;
  logic [DW-1:0]   rsp_q;
  logic            busy, tag_err;

  spmv_mem_arbiter_if mem_if ();

  spmv_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ld    (req_ld),
    .req_st    (req_st),
    .req_addr  (req_addr),
    .req_d     (req_d),
    .req_stall (req_stall),
    .rsp_push  (rsp_push),
    .rsp_q     (rsp_q),
    .rsp_stall (rsp_stall),
    .mem       (mem_if),
    .busy      (busy),
    .tag_err   (tag_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_cnt [N];
  int          m_rr;
  bit          m_ld, m_st, m_err, m_mst;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dt, m_q;
  logic [N-1:0]  m_push;
  int          last_g;

  function automatic int model_grant();
    if (!rst_n || mem_if.mem_req_stall) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if ((req_ld[i] && m_cnt[i] < MO) || req_st[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_stall(int g);
    logic [N-1:0] v;
    v = '1;
    if (g >= 0) v[g] = 1'b0;
    return v;
  endfunction

  function automatic bit exp_busy();
    bit b;
    b = m_ld | m_st | (|(req_ld | req_st));
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic tick();
    int g;
    int t;
    g = model_grant();
    t = int'(mem_if.mem_rsp_tag);
    @(posedge clk);
    last_g = g;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_ld = 0; m_st = 0; m_err = 0; m_mst = 0;
      m_addr = '0; m_dt = '0; m_q = '0; m_push = '0;
    end else begin
      m_ld = (g >= 0) && req_ld[g];
      m_st = (g >= 0) && req_st[g];
      if (g >= 0) begin
        m_addr = req_addr[g*AW +: AW];
        m_dt = req_st[g] ? req_d[g*DW +: DW] : DW'(g);
      end
      for (int i = 0; i < N; i++) begin
        bit inc, dec;
        inc = (g == i) && req_ld[i];
        dec = mem_if.mem_rsp_push && (t == i);
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      m_push = '0;
      if (mem_if.mem_rsp_push && t < N) m_push[t] = 1'b1;
      m_q = mem_if.mem_rsp_q;
      if (mem_if.mem_rsp_push && t >= N) m_err = 1'b1;
      m_mst = |rsp_stall;
      if (g >= 0) m_rr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic idle();
    req_ld = '0; req_st = '0;
    mem_if.mem_req_stall = 1'b0;
    mem_if.mem_rsp_push = 1'b0;
    mem_if.mem_rsp_tag = '0;
    rsp_stall = '0;
  endtask

  task automatic respond(int t, logic [DW-1:0] q);
    mem_if.mem_rsp_push = 1'b1;
    mem_if.mem_rsp_tag = 3'(t);
    mem_if.mem_rsp_q = q;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MO + 2 && m_cnt[i] > 0; k++) begin
        respond(i, 64'(k));
        tick();
      end
    idle();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_ld = '1;
    rsp_stall = '1;
    #1;
    checks++;
    if (req_stall !== 6'h3F) begin
      errors++;
      $display("FAIL rst_stall got %b want 111111", req_stall);
    end
    tick(); tick();
    checks++;
    if (mem_if.mem_req_ld !== 1'b0 || mem_if.mem_req_st !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_req got %b%b want 00",
               mem_if.mem_req_ld, mem_if.mem_req_st);
    end
    checks++;
    if (rsp_push !== '0 || rsp_q !== '0 || tag_err !== 1'b0
        || mem_if.mem_rsp_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp got push=%b q=%h err=%b mst=%b want 0",
               rsp_push, rsp_q, tag_err, mem_if.mem_rsp_stall);
    end
    idle();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
  endtask

  task automatic test_rotation();
    req_ld = '1;
    for (int c = 0; c < 7; c++) begin
      int g;
      #1;
      g = model_grant();
      checks++;
      if (g != c % N || req_stall !== exp_stall(c % N)) begin
        errors++;
        $display("FAIL rot_grant cyc %0d got stall=%b want grant %0d",
                 c, req_stall, c % N);
      end
      tick();
      checks++;
      if (mem_if.mem_req_ld !== 1'b1
          || mem_if.mem_req_d_or_tag !== DW'(c % N)) begin
        errors++;
        $display("FAIL rot_issue cyc %0d got ld=%b tag=%0d want 1 %0d",
                 c, mem_if.mem_req_ld, mem_if.mem_req_d_or_tag, c % N);
      end
    end
    drain();
  endtask

  task automatic test_single();
    req_ld[2] = 1'b1;
    req_addr[2*AW +: AW] = 48'h100;
    #1;
    checks++;
    if (req_stall !== 6'b111011) begin
      errors++;
      $display("FAIL single_stall got %b want 111011", req_stall);
    end
    tick();
    req_ld = '0;
    checks++;
    if (mem_if.mem_req_ld !== 1'b1 || mem_if.mem_req_addr !== 48'h100
        || mem_if.mem_req_d_or_tag !== 64'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got ld=%b a=%h t=%h busy=%b want 1 100 2 1",
               mem_if.mem_req_ld, mem_if.mem_req_addr,
               mem_if.mem_req_d_or_tag, busy);
    end
    tick();
    checks++;
    if (mem_if.mem_req_ld !== 1'b0) begin
      errors++;
      $display("FAIL single_onecyc got ld=%b want 0", mem_if.mem_req_ld);
    end
    respond(2, 64'hDEAD);
    tick();
    idle();
    checks++;
    if (rsp_push !== 6'b000100 || rsp_q !== 64'hDEAD) begin
      errors++;
      $display("FAIL single_rsp got push=%b q=%h want 000100 dead",
               rsp_push, rsp_q);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy got %b want 0", busy);
    end
  endtask

  task automatic test_stall();
    int r0, g;
    req_ld = 6'b011010;
    mem_if.mem_req_stall = 1'b1;
    r0 = m_rr;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_stall !== 6'h3F) begin
        errors++;
        $display("FAIL stall_req cyc %0d got %b want 111111", c, req_stall);
      end
      tick();
      checks++;
      if (mem_if.mem_req_ld !== 1'b0) begin
        errors++;
        $display("FAIL stall_issue cyc %0d got ld=%b want 0",
                 c, mem_if.mem_req_ld);
      end
    end
    mem_if.mem_req_stall = 1'b0;
    #1;
    g = -1;
    for (int k = 0; k < N && g < 0; k++)
      if (req_ld[(r0 + k) % N]) g = (r0 + k) % N;
    checks++;
    if (req_stall !== exp_stall(g)) begin
      errors++;
      $display("FAIL stall_resume got %b want grant %0d", req_stall, g);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (mem_if.mem_req_ld !== 1'b1 || mem_if.mem_req_d_or_tag !== m_dt) begin
        errors++;
        $display("FAIL stall_after cyc %0d got ld=%b t=%0d want 1 %0d",
                 c, mem_if.mem_req_ld, mem_if.mem_req_d_or_tag, m_dt);
      end
    end
    drain();
  endtask

  task automatic test_credit();
    int n0;
    n0 = 0;
    req_ld = 6'b000011;
    for (int c = 0; c < 40; c++) begin
      mem_if.mem_rsp_push = (m_cnt[1] > 0);
      mem_if.mem_rsp_tag = 3'd1;
      #1;
      checks++;
      if (req_stall !== exp_stall(model_grant())) begin
        errors++;
        $display("FAIL credit_stall cyc %0d got %b want %b",
                 c, req_stall, exp_stall(model_grant()));
      end
      if (!req_stall[0]) n0++;
      tick();
    end
    checks++;
    if (n0 != MO) begin
      errors++;
      $display("FAIL credit_count got %0d loads want %0d", n0, MO);
    end
    checks++;
    if (req_stall[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL credit_other got %b want 01", req_stall[1:0]);
    end
    req_ld = 6'b000001;
    respond(0, 64'h0);
    #1;
    checks++;
    if (req_stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL credit_full got %b want 1", req_stall[0]);
    end
    tick();
    #1;
    checks++;
    if (req_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL credit_reopen got %b want 0", req_stall[0]);
    end
    tick();
    mem_if.mem_rsp_push = 1'b0;
    #1;
    checks++;
    if (req_stall[0] !== 1'b0) begin
      errors++;
      $display("FAIL credit_same got %b want 0", req_stall[0]);
    end
    tick();
    checks++;
    if (req_stall[0] !== 1'b1) begin
      errors++;
      $display("FAIL credit_refull got %b want 1", req_stall[0]);
    end
    drain();
  endtask

  task automatic test_store();
    req_st[5] = 1'b1;
    req_addr[5*AW +: AW] = 48'h2000;
    req_d[5*DW +: DW] = 64'h3FF0000000000000;
    #1;
    checks++;
    if (req_stall[5] !== 1'b0) begin
      errors++;
      $display("FAIL store_stall got %b want 0", req_stall[5]);
    end
    tick();
    idle();
    checks++;
    if (mem_if.mem_req_st !== 1'b1 || mem_if.mem_req_ld !== 1'b0
        || mem_if.mem_req_addr !== 48'h2000
        || mem_if.mem_req_d_or_tag !== 64'h3FF0000000000000) begin
      errors++;
      $display("FAIL store_issue got st=%b ld=%b a=%h d=%h",
               mem_if.mem_req_st, mem_if.mem_req_ld,
               mem_if.mem_req_addr, mem_if.mem_req_d_or_tag);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_push !== '0) begin
      errors++;
      $display("FAIL store_nocred got busy=%b push=%b want 0 0",
               busy, rsp_push);
    end
  endtask

  task automatic test_tag_err();
    respond(7, 64'h1234);
    tick();
    idle();
    checks++;
    if (rsp_push !== '0 || tag_err !== 1'b1) begin
      errors++;
      $display("FAIL tag_err got push=%b err=%b want 0 1",
               rsp_push, tag_err);
    end
  endtask

  task automatic test_reset_mid();
    req_ld = 6'b001111;
    repeat (4) tick();
    req_ld = '0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_pre got %b want 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b err=%b want 0 0", busy, tag_err);
    end
    respond(1, 64'hBEEF);
    tick();
    idle();
    checks++;
    if (rsp_push !== 6'b000010 || rsp_q !== 64'hBEEF) begin
      errors++;
      $display("FAIL mid_late got push=%b q=%h want 000010 beef",
               rsp_push, rsp_q);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_cnt got busy=%b want 0", busy);
    end
  endtask

  task automatic new_req(int i);
    int r;
    r = $urandom_range(0, 3);
    req_ld[i] = (r == 1 || r == 2);
    req_st[i] = (r == 3);
    req_addr[i*AW +: AW] = {$urandom, $urandom};
    req_d[i*DW +: DW] = {$urandom, $urandom};
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) new_req(i);
    for (int c = 0; c < 400; c++) begin
      int s;
      rsp_stall = N'($urandom);
      mem_if.mem_req_stall = ($urandom_range(0, 4) == 0);
      mem_if.mem_rsp_push = 1'b0;
      mem_if.mem_rsp_q = {$urandom, $urandom};
      s = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < N; k++)
          if (!mem_if.mem_rsp_push && m_cnt[(s + k) % N] > 0)
            respond((s + k) % N, mem_if.mem_rsp_q);
      if ($urandom_range(0, 99) == 0) respond(6, mem_if.mem_rsp_q);
      #1;
      checks++;
      if (req_stall !== exp_stall(model_grant())) begin
        errors++;
        $display("FAIL rnd_stall cyc %0d got %b want %b",
                 c, req_stall, exp_stall(model_grant()));
      end
      tick();
      checks++;
      if (mem_if.mem_req_ld !== m_ld || mem_if.mem_req_st !== m_st
          || ((m_ld || m_st) && (mem_if.mem_req_addr !== m_addr
              || mem_if.mem_req_d_or_tag !== m_dt))) begin
        errors++;
        $display("FAIL rnd_issue cyc %0d got %b%b %h %h want %b%b %h %h",
                 c, mem_if.mem_req_ld, mem_if.mem_req_st,
                 mem_if.mem_req_addr, mem_if.mem_req_d_or_tag,
                 m_ld, m_st, m_addr, m_dt);
      end
      checks++;
      if (rsp_push !== m_push || rsp_q !== m_q || tag_err !== m_err
          || mem_if.mem_rsp_stall !== m_mst || busy !== exp_busy()) begin
        errors++;
        $display("FAIL rnd_rsp cyc %0d got %b %h %b %b %b want %b %h %b %b %b",
                 c, rsp_push, rsp_q, tag_err, mem_if.mem_rsp_stall, busy,
                 m_push, m_q, m_err, m_mst, exp_busy());
      end
      if (last_g >= 0) new_req(last_g);
      for (int i = 0; i < N; i++)
        if (!req_ld[i] && !req_st[i] && $urandom_range(0, 3) == 0)
          new_req(i);
    end
    drain();
  endtask

  initial begin
    req_addr = '0;
    req_d = '0;
    mem_if.mem_rsp_q = '0;
    idle();
    test_reset();
    test_rotation();
    test_single();
    test_stall();
    test_credit();
    test_store();
    test_tag_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
